// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches under a credit limit
// and buffers in-order responses; a redirect flushes the queue and drops in-flight data.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    input  logic        out_ready
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = CW + OW + 1;
    localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

    logic [31:0]   fetch_addr;
    logic [31:0]   resp_addr;
    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [SW-1:0] credit_used;
    logic          grant;
    logic          push;
    logic          pop;

    // Queue slots already spoken for: stored words plus live in-flight requests.
    always_comb begin
        credit_used = SW'(count) + SW'(outstanding) - SW'(discard);
        mem_req     = !reset && !redirect_valid
                      && (outstanding < OW'(MAX_OUTSTANDING))
                      && (credit_used < SW'(DEPTH));
        grant       = mem_req && mem_gnt;
        push        = mem_rvalid && (discard == '0) && !redirect_valid;
        pop         = (count != '0) && out_ready && !redirect_valid;
    end

    assign mem_addr  = fetch_addr;
    assign out_valid = (count != '0);
    assign out_data  = data_mem[rd_ptr];
    assign out_addr  = addr_mem[rd_ptr];

    // resp_addr tracks the address of the oldest live request; live requests are sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr  <= START_PC;
            resp_addr   <= START_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            fetch_addr  <= redirect_pc & ~32'h3;
            resp_addr   <= redirect_pc & ~32'h3;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - OW'(mem_rvalid);
            discard     <= outstanding - OW'(mem_rvalid);
        end else begin
            if (grant) begin
                fetch_addr <= fetch_addr + 32'd4;
            end
            outstanding <= outstanding + OW'(grant) - OW'(mem_rvalid);
            if (mem_rvalid && (discard != '0)) begin
                discard <= discard - OW'(1);
            end
            if (push) begin
                wr_ptr    <= wr_ptr + PW'(1);
                resp_addr <= resp_addr + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            addr_mem[wr_ptr] <= resp_addr;
            data_mem[wr_ptr] <= mem_rdata;
        end
    end

    rvalid_without_request: assert property (
        @(posedge clk) disable iff (reset) !(mem_rvalid && (outstanding == '0))
    );

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted-but-unanswered memory requests (1..DEPTH).
REQ-003 The module SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous active-high reset.
- redirect_valid  in  1  flush the queue and restart fetch.
- redirect_pc  in  32  restart address; bits [1:0] are ignored.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  32  word-aligned request address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; responses arrive in request order.
- mem_rdata  in  32  read data word.
- out_valid  out  1  queue head valid toward the fetch stage.
- out_data  out  32  head instruction word, raw and possibly holding two compressed halves.
- out_addr  out  32  word address of out_data.
- out_ready  in  1  fetch stage consumes the head this cycle.

Function
REQ-005 The block SHALL hold fetch_addr (32b), a FIFO of DEPTH {addr,data} entries, count (0..DEPTH), outstanding (0..MAX_OUTSTANDING) and discard (0..MAX_OUTSTANDING) counters.
REQ-006 mem_addr SHALL equal fetch_addr, with fetch_addr[1:0] always 2'b00.
REQ-007 mem_req SHALL be asserted when all of the following hold:
- !redirect_valid;
- outstanding < MAX_OUTSTANDING;
- count + (outstanding - discard) < DEPTH.
These conditions are credit-based, so a push into a full queue is impossible.
REQ-008 mem_addr SHALL be held stable while mem_req=1 and mem_gnt=0.
REQ-009 On mem_req & mem_gnt:
- fetch_addr SHALL increment by 4, wrapping modulo 2^32;
- outstanding SHALL increment.
REQ-010 On mem_rvalid:
- outstanding SHALL decrement;
- if discard>0, discard SHALL decrement and the data SHALL be dropped;
- otherwise {address of the oldest live request, mem_rdata} SHALL be pushed.
REQ-011 A pushed word SHALL first appear on out_valid/out_data the cycle after mem_rvalid, with no combinational bypass.
REQ-012 out_valid SHALL equal (count != 0), and out_data/out_addr SHALL show the head entry.
REQ-013 A pop SHALL occur on out_valid & out_ready.
REQ-014 A simultaneous push and pop SHALL leave count unchanged.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH.
REQ-016 On redirect_valid, at the next edge:
- count SHALL become 0 and the FIFO pointers SHALL reset;
- fetch_addr SHALL become {redirect_pc[31:2],2'b00};
- discard SHALL become outstanding minus (1 if mem_rvalid this cycle else 0);
- outstanding SHALL likewise lose the same-cycle response;
- any pop or push in the redirect cycle SHALL be void.
REQ-017 After a redirect, new requests SHALL issue from the next cycle, subject to REQ-007, while discards are still draining.
REQ-018 The block SHALL NOT drop a non-discarded response or reorder responses.
REQ-019 mem_rvalid with outstanding=0 is illegal; an assertion SHALL flag it.

Reset
REQ-020 While reset=1 at a clock edge:
- count, outstanding and discard SHALL clear to 0;
- the FIFO pointers SHALL clear to 0;
- fetch_addr SHALL load RESET_PC & ~3.
REQ-021 During and immediately after reset, outputs SHALL be:
- out_valid=0;
- mem_req=0 in the reset cycle, then 1 the first cycle after reset deasserts;
- mem_addr=RESET_PC.
REQ-022 Reset SHALL override redirect_valid and all handshakes in the same cycle.
REQ-023 Responses to pre-reset requests SHALL NOT arrive after reset (environment guarantee).

Verification
REQ-024 Scenario: RESET_PC=0, gnt always 1, rvalid 1 cycle after gnt, data=addr^32'hA5A5_0000, out_ready=1. Required response: out_addr sequence 0,4,8,... in order, each with matching data, and no gaps after warm-up.
REQ-025 Scenario: out_ready=0, gnt and rvalid always 1, DEPTH=4. Required response:
- exactly 4 grants;
- count=4 and mem_req=0 thereafter;
- raising out_ready for one cycle yields exactly one new grant.
REQ-026 Scenario: two requests (0x10, 0x14) granted, then redirect to 0x103 before either response. Required response:
- both responses dropped;
- next mem_addr=0x100;
- first out_addr=0x100.
REQ-027 Scenario: redirect in the same cycle as a pop and an rvalid. Required response:
- count=0 next cycle;
- that response dropped;
- discard=outstanding-1.
REQ-028 Scenario: gnt held 0 for 5 cycles with mem_req=1. Required response: mem_addr unchanged and no outstanding increment.
REQ-029 Scenario: fetch_addr=0xFFFF_FFFC granted. Required response: next mem_addr=0x0000_0000.
